traffic_ctrl_param: RTL and testbench

Parametrised two-street traffic light controller with pedestrian phase. Successor to the fixed-timing intersection controller.
- Every phase duration is a parameter.
- Adds an all-red clearance interval after each street.
- Pedestrian requests are latched (sticky) rather than sampled once.
- Adds a blinking pedestrian-clearance phase and a night flashing-yellow mode.
- Sits at the top of the intersection design, driving the lamp outputs directly.

---
 rtl/traffic_ctrl_param.sv | 183 ++++++++++++++++++
 tb/tb_traffic_ctrl_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_param.sv
// Two-street traffic light controller with a latched pedestrian phase,
// all-red clearance after each street and a night flashing-yellow mode.
module traffic_ctrl_param #(
    parameter int CW          = 4,
    parameter int T_GREEN1    = 4,
    parameter int T_GREEN2    = 4,
    parameter int T_YELLOW    = 2,
    parameter int T_CLEAR     = 1,
    parameter int T_PED       = 5,
    parameter int T_PED_FLASH = 2,
    parameter int FLASH_HALF  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pedestre,
    input  logic       noturno,
    output logic       rua_1_vermelho,
    output logic       rua_1_amarelo,
    output logic       rua_1_verde,
    output logic       rua_2_vermelho,
    output logic       rua_2_amarelo,
    output logic       rua_2_verde,
    output logic       pedestre_vermelho,
    output logic       pedestre_verde,
    output logic       ped_pending,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        ALL_RED   = 4'd0,
        S1_GREEN  = 4'd1,
        S1_YELLOW = 4'd2,
        CLEAR_1   = 4'd3,
        S2_GREEN  = 4'd4,
        S2_YELLOW = 4'd5,
        CLEAR_2   = 4'd6,
        PED_GREEN = 4'd7,
        PED_FLASH = 4'd8,
        FLASH     = 4'd9
    } state_t;

    // Reload values are duration-1 so a state holding value T lasts T cycles.
    localparam logic [CW-1:0] LD_G1    = CW'(T_GREEN1 - 1);
    localparam logic [CW-1:0] LD_G2    = CW'(T_GREEN2 - 1);
    localparam logic [CW-1:0] LD_Y     = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);
    localparam logic [CW-1:0] LD_PED   = CW'(T_PED - 1);
    localparam logic [CW-1:0] LD_PEDF  = CW'(T_PED_FLASH - 1);
    localparam logic [CW-1:0] LD_HALF  = CW'(FLASH_HALF - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state;
    state_t        succ_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] fcnt;
    logic          phase;

    function automatic logic [CW-1:0] load_of(input state_t s);
        case (s)
            S1_GREEN:             return LD_G1;
            S2_GREEN:             return LD_G2;
            S1_YELLOW, S2_YELLOW: return LD_Y;
            PED_GREEN:            return LD_PED;
            PED_FLASH:            return LD_PEDF;
            default:              return LD_CLEAR;
        endcase
    endfunction

    always_comb begin
        succ_state = ALL_RED;
        case (state)
            ALL_RED:   succ_state = S1_GREEN;
            S1_GREEN:  succ_state = S1_YELLOW;
            S1_YELLOW: succ_state = CLEAR_1;
            CLEAR_1:   succ_state = S2_GREEN;
            S2_GREEN:  succ_state = S2_YELLOW;
            S2_YELLOW: succ_state = CLEAR_2;
            CLEAR_2:   succ_state = ped_pending ? PED_GREEN : S1_GREEN;
            PED_GREEN: succ_state = PED_FLASH;
            PED_FLASH: succ_state = S1_GREEN;
            default:   succ_state = ALL_RED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ALL_RED;
            cnt         <= LD_CLEAR;
            fcnt        <= '0;
            ped_pending <= 1'b0;
            phase       <= 1'b0;
        end else begin
            if (pedestre && !(state inside {PED_GREEN, PED_FLASH, FLASH}))
                ped_pending <= 1'b1;
            case (state)
                FLASH: begin
                    if (fcnt != '0) begin
                        fcnt <= fcnt - ONE;
                    end else if (!noturno) begin
                        state <= ALL_RED;
                        cnt   <= LD_CLEAR;
                        phase <= 1'b0;
                    end else begin
                        fcnt  <= LD_HALF;
                        phase <= ~phase;
                    end
                end
                ALL_RED, S1_GREEN, S1_YELLOW, CLEAR_1, S2_GREEN,
                S2_YELLOW, CLEAR_2, PED_GREEN, PED_FLASH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                        if (state == PED_FLASH)
                            phase <= ~phase;
                    end else if (noturno) begin
                        state       <= FLASH;
                        fcnt        <= LD_HALF;
                        phase       <= 1'b1;
                        ped_pending <= 1'b0;
                    end else begin
                        state <= succ_state;
                        cnt   <= load_of(succ_state);
                        phase <= 1'b0;
                        // Clearing on PED_GREEN entry overrides a same-edge request.
                        if (succ_state == PED_GREEN)
                            ped_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= ALL_RED;
                    cnt   <= LD_CLEAR;
                    phase <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rua_1_vermelho    = 1'b1;
        rua_1_amarelo     = 1'b0;
        rua_1_verde       = 1'b0;
        rua_2_vermelho    = 1'b1;
        rua_2_amarelo     = 1'b0;
        rua_2_verde       = 1'b0;
        pedestre_vermelho = 1'b1;
        pedestre_verde    = 1'b0;
        case (state)
            S1_GREEN: begin
                rua_1_verde    = 1'b1;
                rua_1_vermelho = 1'b0;
            end
            S1_YELLOW: begin
                rua_1_amarelo  = 1'b1;
                rua_1_vermelho = 1'b0;
            end
            S2_GREEN: begin
                rua_2_verde    = 1'b1;
                rua_2_vermelho = 1'b0;
            end
            S2_YELLOW: begin
                rua_2_amarelo  = 1'b1;
                rua_2_vermelho = 1'b0;
            end
            PED_GREEN: begin
                pedestre_verde    = 1'b1;
                pedestre_vermelho = 1'b0;
            end
            PED_FLASH: begin
                pedestre_verde    = phase;
                pedestre_vermelho = 1'b0;
            end
            FLASH: begin
                rua_1_vermelho = 1'b0;
                rua_2_vermelho = 1'b0;
                rua_1_amarelo  = phase;
                rua_2_amarelo  = phase;
            end
            default: ;
        endcase
    end

    assign estado = state;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: directed timeline pins plus randomized
// stimulus compared every cycle against a timeline model of the controller.
module tb_traffic_ctrl_param;

    localparam int T_GREEN1    = 4;
    localparam int T_GREEN2    = 4;
    localparam int T_YELLOW    = 2;
    localparam int T_CLEAR     = 1;
    localparam int T_PED       = 5;
    localparam int T_PED_FLASH = 2;
    localparam int FLASH_HALF  = 2;

    logic       clk;
    logic       reset;
    logic       pedestre;
    logic       noturno;
    logic       r1r, r1y, r1g, r2r, r2y, r2g, pr, pg, ped_pending;
    logic [3:0] estado;

    logic       rst16;
    logic       zero16;
    logic       a_r1r, a_r1y, a_r1g, a_r2r, a_r2y, a_r2g, a_pr, a_pg, a_pend;
    logic [3:0] a_estado;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Model: current state code, cycles already spent in it, latched request.
    int cyc = 0;
    int m_state = 0;
    int m_el = 0;
    bit m_pend = 0;

    int run16 = 0;
    int runs16 = 0;

    traffic_ctrl_param dut (
        .clk(clk), .reset(reset), .pedestre(pedestre), .noturno(noturno),
        .rua_1_vermelho(r1r), .rua_1_amarelo(r1y), .rua_1_verde(r1g),
        .rua_2_vermelho(r2r), .rua_2_amarelo(r2y), .rua_2_verde(r2g),
        .pedestre_vermelho(pr), .pedestre_verde(pg),
        .ped_pending(ped_pending), .estado(estado)
    );

    traffic_ctrl_param #(.CW(4), .T_GREEN1(16)) dut16 (
        .clk(clk), .reset(rst16), .pedestre(zero16), .noturno(zero16),
        .rua_1_vermelho(a_r1r), .rua_1_amarelo(a_r1y), .rua_1_verde(a_r1g),
        .rua_2_vermelho(a_r2r), .rua_2_amarelo(a_r2y), .rua_2_verde(a_r2g),
        .pedestre_vermelho(a_pr), .pedestre_verde(a_pg),
        .ped_pending(a_pend), .estado(a_estado)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        reset    = 1'b1;
        rst16    = 1'b1;
        zero16   = 1'b0;
        pedestre = 1'b0;
        noturno  = 1'b0;
    end

    // ---------------- reference model ----------------
    function automatic int dur(input int s);
        case (s)
            1:       return T_GREEN1;
            4:       return T_GREEN2;
            2, 5:    return T_YELLOW;
            7:       return T_PED;
            8:       return T_PED_FLASH;
            default: return T_CLEAR;
        endcase
    endfunction

    // Bits: r1 red,yellow,green | r2 red,yellow,green | ped red,green
    function automatic logic [7:0] exp_lamps(input int s, input int el);
        logic y;
        logic b;
        y = ((el / FLASH_HALF) % 2) == 0;
        b = (el % 2) == 1;
        case (s)
            1:       return 8'b0011_0010;
            2:       return 8'b0101_0010;
            4:       return 8'b1000_0110;
            5:       return 8'b1000_1010;
            7:       return 8'b1001_0001;
            8:       return {7'b1001000, b};
            9:       return {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b1, 1'b0};
            default: return 8'b1001_0010;
        endcase
    endfunction

    task automatic model_step();
        int nxt;
        bit pend_n;
        if (reset) begin
            m_state = 0;
            m_el    = 0;
            m_pend  = 0;
            cyc     = 0;
            return;
        end
        cyc++;
        pend_n = m_pend | (pedestre && !(m_state inside {7, 8, 9}));
        m_el++;
        if (m_state == 9) begin
            if ((m_el % FLASH_HALF) == 0 && !noturno) begin
                m_state = 0;
                m_el    = 0;
            end
        end else if (m_el == dur(m_state)) begin
            if (noturno)           nxt = 9;
            else if (m_state == 6) nxt = m_pend ? 7 : 1;
            else if (m_state == 8) nxt = 1;
            else                   nxt = m_state + 1;
            if (nxt == 7 || nxt == 9) pend_n = 0;
            m_state = nxt;
            m_el    = 0;
        end
        m_pend = pend_n;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d t=%0t actual=%0h required=%0h", name, cyc, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, exp_lamps(m_state, m_el));
            chk("estado", estado, m_state);
            chk("ped_pending", ped_pending, m_pend);
        end
    end

    always @(negedge clk) begin
        if (!rst16) begin
            if (a_r1g) begin
                run16++;
            end else if (run16 != 0) begin
                chk("g1_len_T16", run16, 16);
                runs16++;
                run16 = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        pedestre = 1'b0;
        noturno  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic go_to(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) chk("go_to_timeout", cyc, c);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Normal cycle with a one-cycle pedestrian pulse, then a held request.
        do_reset(2);
        chk_en = 1'b1;
        rst16  = 1'b0;
        chk("pin_c0_estado", estado, 0);
        chk("pin_c0_model", m_state, 0);
        chk("pin_c0_lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b1001_0010);
        go_to(3);  pedestre = 1'b1;
        chk("pin_c3_r1g", r1g, 1);
        go_to(4);  pedestre = 1'b0;
        chk("pin_c4_pend", ped_pending, 1);
        go_to(5);  chk("pin_c5_r1y", r1y, 1);
        go_to(7);  chk("pin_c7_allred", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b1001_0010);
        go_to(8);  chk("pin_c8_r2g", r2g, 1);
        go_to(12); chk("pin_c12_r2y", r2y, 1);
        go_to(15);
        chk("pin_c15_pg", pg, 1);
        chk("pin_c15_pend", ped_pending, 0);
        chk("pin_c15_model", m_state, 7);
        pedestre = 1'b1;
        go_to(20); chk("pin_c20_lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b1001_0000);
        go_to(21); chk("pin_c21_lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b1001_0001);
        chk("pin_c21_pend", ped_pending, 0);
        go_to(22); pedestre = 1'b0;
        chk("pin_c22_r1g", r1g, 1);
        go_to(28); chk("pin_c28_pend", ped_pending, 0);
        go_to(36); chk("pin_c36_r1g", r1g, 1);

        // Night mode entered from S1_GREEN and left after two half periods.
        do_reset(2);
        go_to(2);  noturno = 1'b1;
        go_to(4);  chk("pin_n4_r1g", r1g, 1);
        go_to(5);
        chk("pin_n5_estado", estado, 9);
        chk("pin_n5_lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b0100_1010);
        go_to(6);  chk("pin_n6_y", {r1y, r2y}, 2'b11);
        go_to(7);  chk("pin_n7_lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b0000_0010);
        go_to(8);  noturno = 1'b0;
        go_to(9);  chk("pin_n9_estado", estado, 0);
        go_to(10); chk("pin_n10_r1g", r1g, 1);

        // Reset in the middle of S2_GREEN with a pending request.
        do_reset(2);
        go_to(2);  pedestre = 1'b1;
        go_to(3);  pedestre = 1'b0;
        go_to(9);
        chk("pin_r9_estado", estado, 4);
        reset = 1'b1;
        @(negedge clk);
        chk("pin_r_estado", estado, 0);
        chk("pin_r_lamps", {r1r, r1y, r1g, r2r, r2y, r2g, pr, pg}, 8'b1001_0010);
        chk("pin_r_pend", ped_pending, 0);
        reset = 1'b0;

        // Randomized traffic: sparse requests, long night periods, rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            pedestre = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 99) == 0) noturno = ~noturno;
            reset = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        reset    = 1'b0;
        noturno  = 1'b0;
        pedestre = 1'b0;
        repeat (3) @(negedge clk);
        chk("g1_T16_runs_seen", runs16 > 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
